if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the program counter, issues single-cycle-qualified requests to instruction memory, and presents registered `if_pc`/`if_inst` pairs that the IF/ID register samples every clock. Handles downstream stall, memory wait states and branch redirect. Inserts a NOP bubble (`32'h0000_0000`) whenever no valid instruction is available.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `clk` in 1: the single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: downstream hazard hold. PC and all outputs freeze while high.
- `branch_flag` in 1: redirect request from ID/EX.
- `branch_target` in 32: redirect address.
- `imem_req` out 1: fetch request (combinational from state).
- `imem_addr` out 32: equals current PC.
- `imem_ack` in 1: `imem_rdata` is valid for the `imem_addr` driven in the same cycle. No outstanding transactions exist.
- `imem_rdata` in 32: fetched word.
- `if_pc` out 32: registered PC of the presented instruction.
- `if_inst` out 32: registered instruction, or 0 for a bubble.
- `if_valid` out 1: registered; `if_inst` is real.
- `if_adel` out 1: registered misaligned-fetch flag (see Configuration).

## Operation
- FSM states:
  - IDLE: reset value; `imem_req`=0; next state FETCH unconditionally, unless an alignment fault is pending.
  - FETCH: `imem_req`=1, `imem_addr`=pc.
  - HOLD: word captured during a stall; `imem_req`=0.
- FETCH with `imem_ack` and !`stall`: `if_pc`<=pc, `if_inst`<=rdata, `if_valid`<=1, pc<=pc+4 (mod 2^32 wrap, no carry out). Stay in FETCH.
- FETCH with `imem_ack` and `stall`: rdata goes into a hold buffer, hold_pc<=pc, go to HOLD. Outputs frozen.
- FETCH without `imem_ack`: if !`stall`, emit a bubble (`if_valid`<=0, `if_inst`<=0, `if_pc`<=pc). If `stall`, outputs frozen.
- HOLD with !`stall`: present the buffer with `if_valid`=1, pc<=hold_pc+4, go to FETCH.
- Redirect: `branch_flag` outranks everything except `reset`.
  - pc<=`branch_target`, state<=FETCH.
  - Any same-cycle ack is dropped and the hold buffer is discarded.
  - If !`stall`, emit a bubble. If `stall`, outputs stay frozen but the redirect is still taken.
- Reset: pc=`RESET_PC`, state=IDLE, `if_pc`=0, `if_inst`=0, `if_valid`=0, `if_adel`=0, `imem_req`=0. Reset mid-fetch abandons the request immediately; no output reflects it.

## Timing
- Reset release at edge N: edge N+1 moves IDLE to FETCH; `imem_req` is high during cycle N+1. With a zero-wait ack, the first `if_valid` is seen after edge N+2.
- Steady state: one instruction per cycle with zero-wait memory.
- Each memory wait cycle adds one bubble.
- Redirect asserted in cycle k: target is fetched in cycle k+1; its instruction appears after edge k+2.
- Stall: outputs hold value for every stalled cycle. The held instruction is released on the first edge with `stall`=0.

## Configuration
- `IF_ALIGN_CHECK_EN` defined:
  - A redirect with `branch_target[1:0]`!=0 does not fetch.
  - On the next non-stalled edge: `if_pc`<=target, `if_inst`<=0, `if_valid`<=1, `if_adel`<=1.
  - FSM parks in IDLE with `imem_req`=0 until the next redirect or reset.
  - `if_adel` clears on the next output update.
- `IF_ALIGN_CHECK_EN` undefined: `branch_target[1:0]` is forced to 00 and `if_adel` is tied to 0.

## Structure
- Package `if_pkg`:
  - FSM state enum {IDLE, FETCH, HOLD}.
  - `NOP_INST`=`32'h0`.
  - `PC_INC`=4.
  - Default `RESET_PC`.
- One combinational sub-module `if_pc_next`: next-PC mux (reset / redirect / increment / hold) with alignment handling.

## Test plan
- Reset release, ack tied high: outputs are 0 in reset. After two edges, `if_pc`=0, 4, 8… on consecutive cycles with matching `if_inst`, `if_valid`=1.
- Ack withheld for 2 cycles at pc=8: two bubbles (`if_inst`=0, `if_valid`=0), then pc 8 presented; no PC skipped.
- Stall for 3 cycles while ack=1 at pc=0x10: outputs frozen. Word for 0x10 appears on the first unstalled edge, then 0x14.
- Redirect to 0x400 concurrent with an ack at 0x20: 0x20 word is never presented. Bubble, then `if_pc`=0x400.
- Redirect to 0x402 with `IF_ALIGN_CHECK_EN`: `if_adel`=1, `if_pc`=0x402, `imem_req` stays 0. Without the macro, 0x400 is fetched.
- Reset asserted mid-HOLD: next edge gives all outputs 0, state IDLE, pc=`RESET_PC`.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } if_state_t;

  // Non-redirect PC update source, chosen by the fetch FSM.
  typedef enum logic [1:0] {
    PC_KEEP,
    PC_STEP,
    PC_STEP_HOLD
  } pc_sel_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_pc_next.sv
// Next-PC selection: reset / redirect / increment / hold.
// IF_ALIGN_CHECK_EN: when defined, misaligned redirect targets are kept and
// flagged; otherwise the target's low two bits are forced to 00.
module if_pc_next
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        reset,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc,
  input  logic [31:0] hold_pc,
  input  pc_sel_t     sel,
  output logic [31:0] pc_next,
  output logic        misaligned
);

  logic [31:0] target;

`ifdef IF_ALIGN_CHECK_EN
  assign target     = branch_target;
  assign misaligned = branch_flag && (branch_target[1:0] != 2'b00);
`else
  logic unused_target_low;
  assign unused_target_low = ^branch_target[1:0];
  assign target     = {branch_target[31:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  // Priority mux; increments wrap modulo 2^32.
  always_comb begin
    pc_next = pc;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (branch_flag) begin
      pc_next = target;
    end else begin
      unique case (sel)
        PC_STEP:      pc_next = pc + PC_INC;
        PC_STEP_HOLD: pc_next = hold_pc + PC_INC;
        default:      pc_next = pc;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding the IF/ID register.
// IF_ALIGN_CHECK_EN: enables the misaligned-redirect fault path (if_adel).
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_flag,
  input  logic [31:0]        branch_target,
  if_fetch_if.master         imem,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic               if_valid,
  output logic               if_adel
);

  if_state_t   state;
  pc_sel_t     sel;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] hold_pc;
  logic [31:0] hold_buf;
  logic        misaligned;
  logic        parked;
  logic        fault_pend;

  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;

  if_pc_next #(
    .RESET_PC (RESET_PC)
  ) u_pc_next (
    .reset         (reset),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .pc            (pc),
    .hold_pc       (hold_pc),
    .sel           (sel),
    .pc_next       (pc_next),
    .misaligned    (misaligned)
  );

  // Decide how the PC advances when neither reset nor redirect applies.
  always_comb begin
    sel = PC_KEEP;
    unique case (state)
      FETCH:   if (imem.imem_ack && !stall) sel = PC_STEP;
      HOLD:    if (!stall) sel = PC_STEP_HOLD;
      default: sel = PC_KEEP;
    endcase
  end

  // Fetch FSM and registered IF/ID-facing outputs.
  // A misaligned redirect parks in IDLE; its fault is presented on the
  // redirect edge if unstalled, otherwise on the first later unstalled edge.
  always_ff @(posedge clk) begin
    pc <= pc_next;
    if (reset) begin
      state      <= IDLE;
      parked     <= 1'b0;
      fault_pend <= 1'b0;
      hold_pc    <= '0;
      hold_buf   <= '0;
      if_pc      <= '0;
      if_inst    <= NOP_INST;
      if_valid   <= 1'b0;
      if_adel    <= 1'b0;
    end else if (branch_flag) begin
      if (misaligned) begin
        state  <= IDLE;
        parked <= 1'b1;
        if (!stall) begin
          fault_pend <= 1'b0;
          if_pc      <= pc_next;
          if_inst    <= NOP_INST;
          if_valid   <= 1'b1;
          if_adel    <= 1'b1;
        end else begin
          fault_pend <= 1'b1;
        end
      end else begin
        state      <= FETCH;
        parked     <= 1'b0;
        fault_pend <= 1'b0;
        if (!stall) begin
          if_pc    <= pc;
          if_inst  <= NOP_INST;
          if_valid <= 1'b0;
          if_adel  <= 1'b0;
        end
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (!parked) state <= FETCH;
          if (fault_pend && !stall) begin
            fault_pend <= 1'b0;
            if_pc      <= pc;
            if_inst    <= NOP_INST;
            if_valid   <= 1'b1;
            if_adel    <= 1'b1;
          end
        end
        FETCH: begin
          if (imem.imem_ack && !stall) begin
            if_pc    <= pc;
            if_inst  <= imem.imem_rdata;
            if_valid <= 1'b1;
            if_adel  <= 1'b0;
          end else if (imem.imem_ack) begin
            hold_buf <= imem.imem_rdata;
            hold_pc  <= pc;
            state    <= HOLD;
          end else if (!stall) begin
            if_pc    <= pc;
            if_inst  <= NOP_INST;
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_pc    <= hold_pc;
            if_inst  <= hold_buf;
            if_valid <= 1'b1;
            if_adel  <= 1'b0;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed scenarios then random traffic,
// compared against a cycle-level behavioural model of the fetch stage.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_adel;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .imem          (bus),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid),
    .if_adel       (if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        adel;
    logic        req;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0000) * 32'h0101_0101) + 32'h0000_1357;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage holds and shows after each edge.
  logic [31:0] m_pc, m_hpc, m_hbuf;
  logic        m_fetching, m_holding, m_parked, m_fault;
  logic [31:0] o_pc, o_inst;
  logic        o_valid, o_adel;

  task automatic show(input logic [31:0] p, input logic [31:0] i, input logic v, input logic a);
    o_pc = p; o_inst = i; o_valid = v; o_adel = a;
  endtask

  task automatic model_edge(input logic rst, input logic st, input logic br,
                            input logic [31:0] tgt, input logic ack);
    logic [31:0] t;
    logic        bad;
    if (rst) begin
      m_pc = RST_PC; m_fetching = 0; m_holding = 0; m_parked = 0; m_fault = 0;
      show(32'h0, 32'h0, 1'b0, 1'b0);
    end else if (br) begin
      t = tgt;
`ifdef IF_ALIGN_CHECK_EN
      bad = (t[1:0] != 2'b00);
`else
      t[1:0] = 2'b00;
      bad = 1'b0;
`endif
      if (!st) begin
        if (bad) show(t, 32'h0, 1'b1, 1'b1);
        else     show(m_pc, 32'h0, 1'b0, 1'b0);
      end
      m_fault    = bad && st;
      m_parked   = bad;
      m_fetching = !bad;
      m_holding  = 0;
      m_pc       = t;
    end else if (m_holding) begin
      if (!st) begin
        show(m_hpc, m_hbuf, 1'b1, 1'b0);
        m_pc = m_hpc + 32'd4;
        m_holding = 0;
        m_fetching = 1;
      end
    end else if (m_fetching) begin
      if (ack && !st) begin
        show(m_pc, mem_word(m_pc), 1'b1, 1'b0);
        m_pc = m_pc + 32'd4;
      end else if (ack) begin
        m_hbuf = mem_word(m_pc);
        m_hpc  = m_pc;
        m_holding = 1;
        m_fetching = 0;
      end else if (!st) begin
        show(m_pc, 32'h0, 1'b0, 1'b0);
      end
    end else begin
      if (m_fault && !st) begin
        show(m_pc, 32'h0, 1'b1, 1'b1);
        m_fault = 0;
      end
      if (!m_parked) m_fetching = 1;
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue the expected result.
  task automatic step(input logic rst, input logic st, input logic br,
                      input logic [31:0] tgt, input logic ack);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    stall         = st;
    branch_flag   = br;
    branch_target = tgt;
    bus.imem_ack  = ack;
    bus.imem_rdata = mem_word(bus.imem_addr);
    model_edge(rst, st, br, tgt, ack);
    e.pc = o_pc; e.inst = o_inst; e.valid = o_valid; e.adel = o_adel;
    e.req = m_fetching; e.addr = m_pc;
    exp_q.push_back(e);
  endtask

  // Monitor: after every rising edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("if_pc",     if_pc,           e.pc);
        chk("if_inst",   if_inst,         e.inst);
        chk("if_valid",  {31'h0, if_valid}, {31'h0, e.valid});
        chk("if_adel",   {31'h0, if_adel},  {31'h0, e.adel});
        chk("imem_req",  {31'h0, bus.imem_req}, {31'h0, e.req});
        chk("imem_addr", bus.imem_addr,   e.addr);
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    reset = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;

    // Reset, release, then zero-wait fetch of 0, 4.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Two wait states at pc=8, then 8 and 0xC.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Stall for three cycles with ack at 0x10, then 0x10, 0x14, 0x18, 0x1C.
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Redirect to 0x400 with a concurrent ack at 0x20.
    step(0, 0, 1, 32'h0000_0400, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Misaligned redirect to 0x402.
    step(0, 0, 1, 32'h0000_0402, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Stalled redirect, then wrap-around past 0xFFFF_FFFC.
    step(0, 1, 1, 32'hFFFF_FFF8, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Enter HOLD, then reset mid-HOLD.
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0),
           tgt,
           ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
